fpu_result_collector: RTL and testbench
=======================================

FPU_RESULT_COLLECTOR -- requirements
Module: fpu_result_collector

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of buffered result entries; legal values are powers of two, 2 to 16.
REQ-002 Clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  SHALL be synchronous and active-high.
REQ-004 Data_In  input  32  SHALL carry the IEEE-754 single result word driven by the FPU Data_Out.
REQ-005 In_Data_Valid  input  1  SHALL mark Data_In as a valid FPU result (driven by FPU Out_Data_Valid); each high cycle is one result.
REQ-006 Out_Ready  input  1  SHALL indicate that the downstream consumer accepts the head entry this cycle.
REQ-007 Out_Data_Valid  output  1  SHALL be high whenever the buffer holds at least one entry.
REQ-008 Data_Out  output  32  SHALL present the head entry result word.
REQ-009 Class_Out  output  3  SHALL present the head entry class: 0 zero, 1 denormal, 2 normal, 3 infinity, 4 NaN; 5-7 unused.
REQ-010 Count  output  log2(DEPTH)+1  SHALL present current occupancy, 0 to DEPTH.
REQ-011 Overflow  output  1  SHALL be a sticky flag set when a result is dropped.
REQ-012 Result_Count  output  16  SHALL count results accepted into the buffer.

Function
REQ-013 Push SHALL occur on a rising edge with In_Data_Valid=1 and either Count<DEPTH or a pop in the same cycle.
REQ-014 Pop SHALL occur on a rising edge with Out_Data_Valid=1 and Out_Ready=1.
REQ-015 Classification SHALL be computed from Data_In at push time and stored with the entry: exp=0x00 & frac=0 -> zero; exp=0x00 & frac!=0 -> denormal; exp=0xFF & frac=0 -> infinity; exp=0xFF & frac!=0 -> NaN; otherwise normal; sign ignored.
REQ-016 Buffer SHALL be first-word-fall-through: Data_Out/Class_Out valid in the same cycle Out_Data_Valid is high, with no read latency.
REQ-017 Latency from a push edge into an empty buffer to Out_Data_Valid=1 SHALL be exactly one cycle (visible after that edge).
REQ-018 Entries SHALL be delivered in push order; read/write pointers wrap modulo DEPTH.
REQ-019 Simultaneous push and pop SHALL leave Count unchanged, including when Count=DEPTH (the push is accepted) and when Count=1.
REQ-020 Push attempt at Count=DEPTH without pop SHALL drop Data_In, set Overflow, and leave buffer contents and Result_Count unchanged.
REQ-021 Pop with Count=0 is impossible (Out_Data_Valid=0); Out_Ready SHALL be ignored while empty.
REQ-022 Result_Count SHALL increment by one per accepted push and saturate at 0xFFFF.
REQ-023 Data_Out and Class_Out SHALL be 0 when Out_Data_Valid=0.
REQ-024 Control state: EMPTY (Count=0), PARTIAL (0<Count<DEPTH), FULL (Count=DEPTH); transitions only via push/pop per REQ-013/014/019.

Reset
REQ-025 On a rising edge with Reset=1: Count=0, pointers=0, Out_Data_Valid=0, Data_Out=0, Class_Out=0, Overflow=0, Result_Count=0.
REQ-026 Reset SHALL take priority over push and pop in the same cycle; In_Data_Valid during Reset is ignored and not counted.
REQ-027 Reset mid-operation SHALL discard all buffered entries; the first push after Reset deassertion behaves as a push into EMPTY.

Verification
REQ-028 Classes: push 0x40533334, 0x80000000, 0x7F800000, 0xFFFFFFFF, 0x000CCD4C with Out_Ready=1 -> Data_Out matches each word one cycle later with Class_Out 2,0,3,4,1; Result_Count=5.
REQ-029 Fill/overflow (DEPTH=4): push 0x3F8CCCCD, 0x40000000, 0x40400000, 0x40800000, 0x40A00000 with Out_Ready=0 -> Count=4, Overflow=1, Result_Count=4; drain yields the first four in order, 0x40A00000 never appears.
REQ-030 Full push+pop: at Count=4, push 0xC01AE148 with Out_Ready=1 -> Count stays 4, Overflow unchanged, 0xC01AE148 emerges fifth after drain.
REQ-031 Wrap: 10 consecutive pushes with Out_Ready=1 every cycle -> Count never exceeds 1, outputs in order, no Overflow, Result_Count=10.
REQ-032 Reset mid-operation: with Count=3, Overflow=1, assert Reset one cycle concurrent with In_Data_Valid=1 -> all outputs 0 next cycle; next push 0x3F800000 appears alone with Class_Out=2, Result_Count=1.
REQ-033 Saturation: force 65537 accepted pushes -> Result_Count=0xFFFF.

Source files
------------

// File: rtl/fpu_result_collector.sv
// FPU result collector: a first-word-fall-through buffer that stores each
// FPU result together with its IEEE-754 class, delivers entries in push
// order, and keeps a sticky drop flag and a saturating accepted-result count.
//
// state     | meaning
// ----------+-------------------------------------------
// S_EMPTY   | no entries held, output side idle
// S_PARTIAL | between one and DEPTH-1 entries held
// S_FULL    | DEPTH entries held, a lone push is dropped
module fpu_result_collector #(
    parameter int DEPTH = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [31:0]              Data_In,
    input  logic                     In_Data_Valid,
    input  logic                     Out_Ready,
    output logic                     Out_Data_Valid,
    output logic [31:0]              Data_Out,
    output logic [2:0]               Class_Out,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow,
    output logic [15:0]              Result_Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [31:0]     mem_data [DEPTH];
    logic [2:0]      mem_class [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;
    logic            drop;

    // Class codes: 0 zero, 1 denormal, 2 normal, 3 infinity, 4 NaN (sign ignored).
    function automatic logic [2:0] classify(input logic [31:0] word);
        logic [7:0]  exp_f;
        logic [22:0] frac_f;
        exp_f  = word[30:23];
        frac_f = word[22:0];
        if (exp_f == 8'h00)
            classify = (frac_f == '0) ? 3'd0 : 3'd1;
        else if (exp_f == 8'hFF)
            classify = (frac_f == '0) ? 3'd3 : 3'd4;
        else
            classify = 3'd2;
    endfunction

    // Occupancy state register.
    always_ff @(posedge Clock) begin
        if (Reset)
            state <= S_EMPTY;
        else
            state <= state_next;
    end

    // Push/pop decisions and next occupancy state; a push into a full buffer
    // is only accepted when the head leaves in the same cycle.
    always_comb begin
        pop        = 1'b0;
        push       = 1'b0;
        drop       = 1'b0;
        count_next = count_q;
        state_next = state;

        pop  = (state != S_EMPTY) && Out_Ready;
        push = In_Data_Valid && ((state != S_FULL) || pop);
        drop = In_Data_Valid && (state == S_FULL) && !pop;

        case ({push, pop})
            2'b10:   count_next = count_q + CW'(1);
            2'b01:   count_next = count_q - CW'(1);
            default: count_next = count_q;
        endcase

        if (count_next == '0)
            state_next = S_EMPTY;
        else if (count_next == CW'(DEPTH))
            state_next = S_FULL;
        else
            state_next = S_PARTIAL;
    end

    // Entry storage; contents behind the pointers need no reset.
    always_ff @(posedge Clock) begin
        if (!Reset && push) begin
            mem_data[wr_ptr]  <= Data_In;
            mem_class[wr_ptr] <= classify(Data_In);
        end
    end

    // Pointers, occupancy, sticky drop flag and saturating result counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count_q      <= '0;
            Overflow     <= 1'b0;
            Result_Count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count_q <= count_next;
            if (drop)
                Overflow <= 1'b1;
            if (push && (Result_Count != 16'hFFFF))
                Result_Count <= Result_Count + 16'd1;
        end
    end

    // Head entry falls through with no read latency; outputs forced to zero when empty.
    always_comb begin
        Out_Data_Valid = (state != S_EMPTY);
        Count          = count_q;
        Data_Out       = '0;
        Class_Out      = '0;
        if (Out_Data_Valid) begin
            Data_Out  = mem_data[rd_ptr];
            Class_Out = mem_class[rd_ptr];
        end
    end

endmodule

// File: tb/tb_fpu_result_collector.sv
// Testbench for fpu_result_collector: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_fpu_result_collector;

    localparam int DEPTH = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Data_In = '0;
    logic        In_Data_Valid = 1'b0;
    logic        Out_Ready = 1'b0;
    logic        Out_Data_Valid;
    logic [31:0] Data_Out;
    logic [2:0]  Class_Out;
    logic [$clog2(DEPTH):0] Count;
    logic        Overflow;
    logic [15:0] Result_Count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_q[$];
    bit          m_ovf = 0;
    int          m_rc  = 0;
    int          max_cnt;

    fpu_result_collector #(.DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset), .Data_In(Data_In),
        .In_Data_Valid(In_Data_Valid), .Out_Ready(Out_Ready),
        .Out_Data_Valid(Out_Data_Valid), .Data_Out(Data_Out),
        .Class_Out(Class_Out), .Count(Count), .Overflow(Overflow),
        .Result_Count(Result_Count)
    );

    always #5 Clock = ~Clock;

    function automatic int ref_class(input logic [31:0] w);
        int e, f;
        e = int'((w >> 23) & 32'hFF);
        f = int'(w & 32'h7FFFFF);
        if (e == 0)   return (f == 0) ? 0 : 1;
        if (e == 255) return (f == 0) ? 3 : 4;
        return 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_data;
        logic [31:0] e_cls;
        e_data = (m_q.size() > 0) ? m_q[0] : 32'h0;
        e_cls  = (m_q.size() > 0) ? 32'(ref_class(m_q[0])) : 32'h0;
        check({tag, ".valid"}, 32'(Out_Data_Valid), 32'(m_q.size() > 0));
        check({tag, ".data"},  Data_Out, e_data);
        check({tag, ".class"}, 32'(Class_Out), e_cls);
        check({tag, ".count"}, 32'(Count), 32'(m_q.size()));
        check({tag, ".ovf"},   32'(Overflow), 32'(m_ovf));
        check({tag, ".rc"},    32'(Result_Count), 32'(m_rc));
    endtask

    // Drive one cycle, update the model with the rules, then compare.
    task automatic step(input string tag, input bit v, input logic [31:0] d,
                        input bit r, input bit rst = 1'b0);
        bit do_pop, do_push;
        Reset = rst; In_Data_Valid = v; Data_In = d; Out_Ready = r;
        @(posedge Clock);
        if (rst) begin
            m_q.delete(); m_ovf = 0; m_rc = 0;
        end else begin
            do_pop  = (m_q.size() > 0) && r;
            do_push = v && ((m_q.size() < DEPTH) || do_pop);
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(d);
                if (m_rc < 65535) m_rc++;
            end
            if (v && !do_push) m_ovf = 1;
        end
        #1;
        if (int'(Count) > max_cnt) max_cnt = int'(Count);
        check_all(tag);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int kind;
        w = $urandom;
        kind = $urandom_range(0, 4);
        case (kind)
            0: w[30:0] = 31'h0;
            1: w[30:23] = 8'h00;
            2: w[30:23] = 8'hFF;
            3: w[30:0] = {8'hFF, 23'h0};
            default: ;
        endcase
        return w;
    endfunction

    logic [31:0] cls_words [5] = '{32'h40533334, 32'h80000000, 32'h7F800000, 32'hFFFFFFFF, 32'h000CCD4C};
    logic [31:0] fill_words[5] = '{32'h3F8CCCCD, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    logic [2:0]  cls_exp   [5] = '{3'd2, 3'd0, 3'd3, 3'd4, 3'd1};

    initial begin
        // Reset, with a valid push that must be ignored
        step("rst0", 1, 32'h3F800000, 1, 1);
        step("rst1", 0, 0, 0, 1);
        step("idle", 0, 0, 1);

        // Class sequence, ready held high: each word appears one cycle after push
        for (int i = 0; i < 5; i++) begin
            step("cls", 1, cls_words[i], 1);
            check("cls.word", Data_Out, cls_words[i]);
            check("cls.code", 32'(Class_Out), 32'(cls_exp[i]));
        end
        step("cls.drain", 0, 0, 1);
        check("cls.rc", 32'(Result_Count), 32'd5);

        // Fill and overflow
        step("rst", 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step("fill", 1, fill_words[i], 0);
        check("fill.count", 32'(Count), 32'd4);
        check("fill.ovf", 32'(Overflow), 32'd1);
        check("fill.rc", 32'(Result_Count), 32'd4);

        // Push and pop together while full
        step("fullpp", 1, 32'hC01AE148, 1);
        check("fullpp.count", 32'(Count), 32'd4);
        for (int i = 1; i < 4; i++) begin
            check("drain.order", Data_Out, fill_words[i]);
            step("drain", 0, 0, 1);
        end
        check("drain.fifth", Data_Out, 32'hC01AE148);
        step("drain", 0, 0, 1);
        step("drain.empty", 0, 0, 1);

        // Wrap: ten back-to-back pushes with ready held high
        step("rst", 0, 0, 0, 1);
        max_cnt = 0;
        for (int i = 0; i < 10; i++) step("wrap", 1, 32'h41000000 + 32'(i), 1);
        step("wrap.drain", 0, 0, 1);
        check("wrap.maxcnt", 32'(max_cnt), 32'd1);
        check("wrap.rc", 32'(Result_Count), 32'd10);
        check("wrap.ovf", 32'(Overflow), 32'd0);

        // Reset mid-operation with Count=3 and Overflow set
        step("rst", 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step("mid.fill", 1, fill_words[i], 0);
        step("mid.pop", 0, 0, 1);
        check("mid.count3", 32'(Count), 32'd3);
        check("mid.ovf1", 32'(Overflow), 32'd1);
        step("mid.rst", 1, 32'h12345678, 1, 1);
        check("mid.rst.data", Data_Out, 32'h0);
        check("mid.rst.rc", 32'(Result_Count), 32'd0);
        step("mid.push", 1, 32'h3F800000, 0);
        check("mid.word", Data_Out, 32'h3F800000);
        check("mid.class", 32'(Class_Out), 32'd2);
        check("mid.rc", 32'(Result_Count), 32'd1);
        check("mid.count1", 32'(Count), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++)
            step("rand", $urandom_range(0, 99) < 60, rand_word(), $urandom_range(0, 99) < 50);

        // Saturation of the accepted-result counter
        step("rst", 0, 0, 0, 1);
        for (int i = 0; i < 65537; i++) step("sat", 1, 32'h40000000 ^ 32'(i), 1);
        check("sat.rc", 32'(Result_Count), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
